// File: rtl/contador_nbit.sv
// Free-running unsigned up-counter of nbits width with a combinational
// terminal-count flag; asynchronous active-low reset clears the count.
module contador_nbit #(
  parameter int unsigned nbits = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [nbits-1:0] out,
  output logic             tc
);

  logic [nbits-1:0] count_q;
  logic [nbits-1:0] count_d;

  // Natural truncation gives the modulo-2^nbits wrap from all ones to zero.
  always_comb begin
    count_d = count_q + nbits'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;
  assign tc  = &count_q;

endmodule

// File: tb/tb_contador_nbit.sv
// Bench for contador_nbit at widths 1, 4 and 8 sharing one clock with
// independent resets; an edge-count reference model is checked every cycle.
module tb_contador_nbit;

  logic       clk;
  logic       rst1, rst4, rst8;
  logic [0:0] out1;
  logic [3:0] out4;
  logic [7:0] out8;
  logic       tc1, tc4, tc8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          per_cycle_en = 1'b0;

  // Reference: rising edges seen with reset high since the last reset.
  int unsigned e1 = 0, e4 = 0, e8 = 0;

  contador_nbit #(.nbits(1)) u_c1 (.clk(clk), .reset(rst1), .out(out1), .tc(tc1));
  contador_nbit #(.nbits(4)) u_c4 (.clk(clk), .reset(rst4), .out(out4), .tc(tc4));
  contador_nbit #(.nbits(8)) u_c8 (.clk(clk), .reset(rst8), .out(out8), .tc(tc8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    e1 <= rst1 ? e1 + 1 : 0;
    e4 <= rst4 ? e4 + 1 : 0;
    e8 <= rst8 ? e8 + 1 : 0;
  end

  function automatic int unsigned exp_cnt(int unsigned e, int unsigned n, logic r);
    int unsigned m;
    m = 32'd1 << n;
    return r ? (e % m) : 0;
  endfunction

  function automatic int unsigned exp_tc(int unsigned e, int unsigned n, logic r);
    int unsigned m;
    m = 32'd1 << n;
    return (exp_cnt(e, n, r) == m - 1) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out1"}, 32'(out1), exp_cnt(e1, 1, rst1));
    check({tag, "_tc1"},  32'(tc1),  exp_tc(e1, 1, rst1));
    check({tag, "_out4"}, 32'(out4), exp_cnt(e4, 4, rst4));
    check({tag, "_tc4"},  32'(tc4),  exp_tc(e4, 4, rst4));
    check({tag, "_out8"}, 32'(out8), exp_cnt(e8, 8, rst8));
    check({tag, "_tc8"},  32'(tc8),  exp_tc(e8, 8, rst8));
  endtask

  always @(negedge clk) begin
    if (per_cycle_en) check_all("cyc");
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b0;
    rst4 = 1'b0;
    rst8 = 1'b0;
    #1;
    check("rst_out4", 32'(out4), 0);
    check("rst_tc4",  32'(tc4),  0);

    // Held in reset across several edges.
    repeat (3) after_edge();
    check("hold_out1", 32'(out1), 0);
    check("hold_out8", 32'(out8), 0);
    per_cycle_en = 1'b1;

    // Release 1 unit after an edge: 0 until next edge, then 1, 2, 3.
    rst1 = 1'b1;
    rst4 = 1'b1;
    rst8 = 1'b1;
    #1;
    check("rel_out4_0", 32'(out4), 0);
    after_edge();
    check("rel_out4_1", 32'(out4), 1);
    check("rel_out1_1", 32'(out1), 1);
    check("rel_tc1_1",  32'(tc1),  1);
    after_edge();
    check("rel_out4_2", 32'(out4), 2);
    check("rel_out1_0", 32'(out1), 0);
    check("rel_tc1_0",  32'(tc1),  0);
    after_edge();
    check("rel_out4_3", 32'(out4), 3);

    // Run to 4-bit terminal count and wrap.
    repeat (12) after_edge();
    check("w4_out15", 32'(out4), 15);
    check("w4_tc15",  32'(tc4),  1);
    after_edge();
    check("w4_out0", 32'(out4), 0);
    check("w4_tc0",  32'(tc4),  0);

    // Run to 8-bit terminal count and wrap (256 edges after release).
    repeat (239) after_edge();
    check("w8_out255", 32'(out8), 255);
    check("w8_tc255",  32'(tc8),  1);
    after_edge();
    check("w8_out0", 32'(out8), 0);
    check("w8_tc0",  32'(tc8),  0);

    // Asynchronous assertion mid-cycle at out4 = 5.
    for (int i = 0; i < 20 && (e4 % 16) != 5; i++) after_edge();
    check("pre_out4_5", 32'(out4), 5);
    #2;
    rst4 = 1'b0;
    #1;
    check("async_out4", 32'(out4), 0);
    check("async_tc4",  32'(tc4),  0);
    repeat (3) after_edge();
    check("held_out4", 32'(out4), 0);
    rst4 = 1'b1;
    #1;
    check("rel2_out4_0", 32'(out4), 0);
    for (int k = 1; k <= 3; k++) begin
      after_edge();
      check("rel2_out4", 32'(out4), k);
    end

    // Asynchronous clear exactly at all ones.
    for (int i = 0; i < 20 && (e4 % 16) != 15; i++) after_edge();
    check("pre_out4_15", 32'(tc4), 1);
    #2;
    rst4 = 1'b0;
    #1;
    check("async15_out4", 32'(out4), 0);
    check("async15_tc4",  32'(tc4),  0);
    after_edge();
    rst4 = 1'b1;

    // Randomized reset activity: synchronous-phase changes and mid-cycle asserts.
    for (int c = 0; c < 600; c++) begin
      after_edge();
      rst1 = ($urandom_range(0, 11) != 0);
      rst4 = ($urandom_range(0, 11) != 0);
      rst8 = ($urandom_range(0, 31) != 0);
      #1;
      check_all("rnd_rel");
      if ($urandom_range(0, 9) == 0) begin
        #1;
        case ($urandom_range(0, 2))
          0: rst1 = 1'b0;
          1: rst4 = 1'b0;
          default: rst8 = 1'b0;
        endcase
        #1;
        check_all("rnd_async");
      end
    end

    per_cycle_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/contador_nbit.md
CONTADOR_NBIT -- requirements
Module: contador_nbit

Interface
REQ-001 Parameter: nbits, default 1, counter width in bits; legal range 1..32.
REQ-002 Ports (positional order clk, reset, out, tc):
REQ-003 clk  input  1  sole clock; all state changes on its rising edge, except reset.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears the counter immediately.
REQ-005 out  output  nbits  current count value, registered.
REQ-006 tc  output  1  terminal count; high while out equals all ones (2^nbits - 1).
REQ-007 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low.

Function
REQ-008 While reset is high, out SHALL increment by 1 on every rising clk edge.
REQ-009 Arithmetic SHALL be unsigned modulo 2^nbits: out = 2^nbits - 1 SHALL wrap to 0 on the next edge.
REQ-010 No carry, overflow or sticky flag SHALL exist beyond tc.
REQ-011 tc SHALL be decoded combinationally from the out register, with no extra cycle of latency.
REQ-012 tc SHALL be high for exactly one clock period per wrap cycle when reset stays high.
REQ-013 For nbits = 1, out SHALL toggle 0,1,0,1,...; tc SHALL equal out.
REQ-014 Latency: a change at out SHALL be visible after the rising edge that causes it, within the same time step as the edge.
REQ-015 There SHALL be no enable, load or direction control; counting is unconditional outside reset.

Reset
REQ-016 reset low SHALL force out to 0 and tc to 0 (tc to 1 only if nbits... n/a, since 0 != all ones for nbits >= 1) without waiting for a clk edge.
REQ-017 While reset is held low, out SHALL stay 0 across any number of clk edges.
REQ-018 When reset deasserts, out SHALL stay 0 until the first rising clk edge after release, then go to 1.
REQ-019 Assertion mid-count (any value, including 2^nbits - 1) SHALL clear out to 0 immediately; no partial increment.
REQ-020 Reset release coincident with a clk edge: that edge SHALL NOT increment; counting starts on the following edge.
REQ-021 Out SHALL be 0 after reset. Without any reset, the power-up value is undefined and need not be handled.

Structure
REQ-022 A single flat module SHALL be used: one nbits-wide register, one incrementer and one all-ones comparator.
REQ-023 No shared package is required; nbits is the only constant and SHALL remain a module parameter.
REQ-024 No sub-module SHALL be instantiated.
REQ-025 The block SHALL be instantiable at several widths in one design without name collisions.

Verification
REQ-026 Bench SHALL instantiate nbits = 1, 4 and 8 together on one clk with independent resets.
REQ-027 nbits=1, reset high for 4 edges -> out 1,0,1,0; tc 1,0,1,0.
REQ-028 nbits=4, reset high for 16 edges from 0 -> out 1..15 then 0; tc high only while out=15.
REQ-029 nbits=8, reset high for 256 edges -> out reaches 255 (tc=1), then wraps to 0 (tc=0).
REQ-030 nbits=4, out=5, reset driven low between edges -> out=0 at once, before the next clk edge; stays 0 for 3 held edges.
REQ-031 Release reset 1 time unit after an edge -> out=0 until the next edge, then 1, 2, 3 on successive edges.
REQ-032 Bench SHALL count mismatches against a reference model every cycle and report zero errors at end of run.
